// File: rtl/control_fsm.sv
// control_fsm: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the Lapido core, all outputs registered.
// Latency (accept edge to instrReady, inclusive): ALU/loadlit/branch 4, NOP 3, illegal 2, load/store 5 + memReady waits.
// Backpressure: instrReady only in FETCH; MEM stalls on memReady and aborts after MEM_TIMEOUT waits (0 = never).
module control_fsm #(
   parameter int INSTR_WIDTH = 32,
   parameter int ALUOP_WIDTH = 5,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic                   clock,
   input  logic                   resetN,
   input  logic [INSTR_WIDTH-1:0] instruction,
   input  logic                   instrValid,
   output logic                   instrReady,
   input  logic                   aluZero,
   input  logic                   memReady,
   output logic                   branch,
   output logic                   pcSrc,
   output logic                   pcEnable,
   output logic                   memRead,
   output logic                   memWrite,
   output logic                   memToReg,
   output logic [ALUOP_WIDTH-1:0] ALUOp,
   output logic                   ALUSrc,
   output logic                   regWrite,
   output logic                   registerB,
   output logic                   illegal,
   output logic                   memTimeout,
   output logic                   busy
);
   localparam int IW = INSTR_WIDTH;
   localparam int AW = ALUOP_WIDTH;
   // One spare counter bit keeps the width legal when the timeout is disabled.
   localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] CNT_MAX  = (MEM_TIMEOUT > 0) ? CW'(MEM_TIMEOUT) : {CW{1'b1}};
   localparam logic [CW-1:0] CNT_LAST = (MEM_TIMEOUT > 0) ? CW'(MEM_TIMEOUT - 1) : '0;

   typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} stateT;

   typedef struct packed {
      logic          bad;
      logic          isNop;
      logic          isLoad;
      logic          isStore;
      logic          isJump;
      logic          isBeq;
      logic          isBne;
      logic          isBranch;
      logic          writes;
      logic          useImm;
      logic          selB;
      logic          toReg;
      logic [AW-1:0] op;
   } decT;

   // Class is the top 3 bits, function the next 5; anything unlisted is illegal.
   function automatic decT decode(input logic [IW-1:0] w);
      logic [2:0] c;
      logic [4:0] f;
      decT        d;
      c = w[IW-1 -: 3];
      f = w[IW-4 -: 5];
      d = '0;
      case (c)
         3'b001: begin
            d.op     = w[IW-4 -: AW];
            d.writes = 1'b1;
         end
         3'b100: begin
            d.useImm = 1'b1;
            if (f[0]) begin
               d.isStore = 1'b1;
               d.selB    = 1'b1;
            end else begin
               d.isLoad = 1'b1;
               d.toReg  = 1'b1;
               d.writes = 1'b1;
            end
         end
         3'b010: begin
            if (f[1:0] == 2'b10) begin
               d.useImm = 1'b1;
               d.writes = 1'b1;
            end else begin
               d.bad = 1'b1;
            end
         end
         3'b000: begin
            d.useImm = 1'b1;
            d.isNop  = 1'b1;
         end
         3'b101: begin
            d.isBranch = 1'b1;
            d.selB     = 1'b1;
            case (f[4:2])
               3'b000:  begin d.isJump = 1'b1; d.op = AW'(5'b01010); end
               3'b001:  begin d.isBeq  = 1'b1; d.op = AW'(5'b00010); end
               3'b010:  begin d.isBne  = 1'b1; d.op = AW'(5'b00111); end
               default: begin d.isBranch = 1'b0; d.selB = 1'b0; d.bad = 1'b1; end
            endcase
         end
         default: d.bad = 1'b1;
      endcase
      return d;
   endfunction

   stateT         state, stateNxt;
   logic [IW-1:0] ir;
   logic [CW-1:0] waitCnt, cntNxt;
   logic          irLoad;
   decT           dIn, dIr;
   logic [AW-1:0] aluOpNxt;
   logic          aluSrcNxt, regBNxt, branchNxt, memToRegNxt, pcSrcNxt;
   logic          memReadNxt, memWriteNxt, regWriteNxt, pcEnableNxt;
   logic          illegalNxt, memTimeoutNxt, instrReadyNxt;
   logic          unusedBits;

   // Decode the incoming word at accept so its outputs are live during DECODE; later states use the latched IR.
   assign dIn        = decode(instruction);
   assign dIr        = decode(ir);
   assign unusedBits = ^{instruction, ir, dIn, dIr};

   // Next state and next registered outputs; decoded fields hold unless changed, pulses default low.
   always_comb begin
      stateNxt      = state;
      irLoad        = 1'b0;
      cntNxt        = waitCnt;
      aluOpNxt      = ALUOp;
      aluSrcNxt     = ALUSrc;
      regBNxt       = registerB;
      branchNxt     = branch;
      memToRegNxt   = memToReg;
      pcSrcNxt      = pcSrc;
      memReadNxt    = memRead;
      memWriteNxt   = memWrite;
      regWriteNxt   = 1'b0;
      pcEnableNxt   = 1'b0;
      illegalNxt    = 1'b0;
      memTimeoutNxt = 1'b0;
      case (state)
         FETCH: begin
            if (instrReady && instrValid) begin
               stateNxt    = DECODE;
               irLoad      = 1'b1;
               aluOpNxt    = dIn.op;
               aluSrcNxt   = dIn.useImm;
               regBNxt     = dIn.selB;
               branchNxt   = dIn.isBranch;
               memToRegNxt = dIn.toReg;
               illegalNxt  = dIn.bad;
            end
         end
         DECODE: begin
            if (dIr.bad) begin
               stateNxt = FETCH;
            end else if (dIr.isNop) begin
               stateNxt    = WB;
               pcEnableNxt = 1'b1;
            end else begin
               stateNxt = EXEC;
            end
         end
         EXEC: begin
            if (dIr.isLoad || dIr.isStore) begin
               stateNxt    = MEM;
               memReadNxt  = ~dIr.isLoad;
               memWriteNxt = ~dIr.isStore;
               cntNxt      = '0;
            end else begin
               stateNxt    = WB;
               regWriteNxt = dIr.writes;
               pcEnableNxt = 1'b1;
               if (dIr.isBranch) begin
                  pcSrcNxt = dIr.isJump | (dIr.isBeq & aluZero) | (dIr.isBne & ~aluZero);
               end
            end
         end
         MEM: begin
            if (memReady) begin
               stateNxt    = WB;
               memReadNxt  = 1'b1;
               memWriteNxt = 1'b1;
               regWriteNxt = dIr.writes;
               pcEnableNxt = 1'b1;
            end else if ((MEM_TIMEOUT > 0) && (waitCnt == CNT_LAST)) begin
               stateNxt      = FETCH;
               memReadNxt    = 1'b1;
               memWriteNxt   = 1'b1;
               memTimeoutNxt = 1'b1;
            end else if (waitCnt != CNT_MAX) begin
               cntNxt = waitCnt + CW'(1);
            end
         end
         WB: begin
            stateNxt = FETCH;
         end
         default: begin
            stateNxt = FETCH;
         end
      endcase
      // Returning to FETCH puts every datapath control back at its reset value.
      if ((stateNxt == FETCH) && (state != FETCH)) begin
         aluOpNxt    = '0;
         aluSrcNxt   = 1'b0;
         regBNxt     = 1'b0;
         branchNxt   = 1'b0;
         memToRegNxt = 1'b0;
         pcSrcNxt    = 1'b0;
         memReadNxt  = 1'b1;
         memWriteNxt = 1'b1;
      end
      instrReadyNxt = (stateNxt == FETCH);
   end

   // State, IR, wait counter and every output register; reset forces FETCH from any state.
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         state      <= FETCH;
         ir         <= '0;
         waitCnt    <= '0;
         instrReady <= 1'b0;
         busy       <= 1'b0;
         branch     <= 1'b0;
         pcSrc      <= 1'b0;
         pcEnable   <= 1'b0;
         memRead    <= 1'b1;
         memWrite   <= 1'b1;
         memToReg   <= 1'b0;
         ALUOp      <= '0;
         ALUSrc     <= 1'b0;
         regWrite   <= 1'b0;
         registerB  <= 1'b0;
         illegal    <= 1'b0;
         memTimeout <= 1'b0;
      end else begin
         state      <= stateNxt;
         if (irLoad) begin
            ir <= instruction;
         end
         waitCnt    <= cntNxt;
         instrReady <= instrReadyNxt;
         busy       <= ~instrReadyNxt;
         branch     <= branchNxt;
         pcSrc      <= pcSrcNxt;
         pcEnable   <= pcEnableNxt;
         memRead    <= memReadNxt;
         memWrite   <= memWriteNxt;
         memToReg   <= memToRegNxt;
         ALUOp      <= aluOpNxt;
         ALUSrc     <= aluSrcNxt;
         regWrite   <= regWriteNxt;
         registerB  <= regBNxt;
         illegal    <= illegalNxt;
         memTimeout <= memTimeoutNxt;
      end
   end
endmodule

// File: tb/tb_control_fsm.sv
// tb_control_fsm: directed instructions for control_fsm with a queue-based scoreboard.
// Latency: one scoreboard record per instruction, retired when instrReady returns.
// Backpressure: a memory responder answers strobes after a per-instruction delay (or never).
module tb_control_fsm;
   localparam int IW = 32;
   localparam int AW = 5;
   localparam int MT = 15;

   logic          clock = 1'b0;
   logic          resetN;
   logic [IW-1:0] instruction;
   logic          instrValid, aluZero, memReady;
   logic          instrReady, branch, pcSrc, pcEnable, memRead, memWrite, memToReg;
   logic [AW-1:0] ALUOp;
   logic          ALUSrc, regWrite, registerB, illegal, memTimeout, busy;

   control_fsm #(.INSTR_WIDTH(IW), .ALUOP_WIDTH(AW), .MEM_TIMEOUT(MT)) dut (
      .clock(clock), .resetN(resetN), .instruction(instruction), .instrValid(instrValid),
      .instrReady(instrReady), .aluZero(aluZero), .memReady(memReady), .branch(branch),
      .pcSrc(pcSrc), .pcEnable(pcEnable), .memRead(memRead), .memWrite(memWrite),
      .memToReg(memToReg), .ALUOp(ALUOp), .ALUSrc(ALUSrc), .regWrite(regWrite),
      .registerB(registerB), .illegal(illegal), .memTimeout(memTimeout), .busy(busy)
   );

   always #5 clock = ~clock;

   typedef struct {
      int id;
      int busyCyc;
      int rdLow;
      int wrLow;
      int regWr;
      int pcEn;
      int pcSrcAtEn;
      int memToReg;
      int aluOp;
      int aluSrc;
      int regB;
      int branch;
      int ill;
      int tmo;
      int bothLow;
      int busyBad;
      int clean;
   } recT;

   recT expQ[$];
   int  nCompared = 0;
   int  nFailed   = 0;
   int  memDelay  = -1;   // <0: memReady always high; otherwise cycles of strobe before ready

   task automatic check(input string name, input int act, input int exp);
      nCompared++;
      if (act != exp) begin
         nFailed++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic recT mk(input int id, busyC, rd, wr, rw, pe, ps, m2r, op, src, rb, br, ill, tmo);
      recT r;
      r.id = id; r.busyCyc = busyC; r.rdLow = rd; r.wrLow = wr; r.regWr = rw; r.pcEn = pe;
      r.pcSrcAtEn = ps; r.memToReg = m2r; r.aluOp = op; r.aluSrc = src; r.regB = rb;
      r.branch = br; r.ill = ill; r.tmo = tmo; r.bothLow = 0; r.busyBad = 0; r.clean = 1;
      return r;
   endfunction

   task automatic compareRec(input recT a, input recT e);
      string p;
      p = $sformatf("instr%0d", e.id);
      check({p, "_busyCycles"}, a.busyCyc, e.busyCyc);
      check({p, "_memReadLow"}, a.rdLow, e.rdLow);
      check({p, "_memWriteLow"}, a.wrLow, e.wrLow);
      check({p, "_regWrite"}, a.regWr, e.regWr);
      check({p, "_pcEnable"}, a.pcEn, e.pcEn);
      check({p, "_pcSrc"}, a.pcSrcAtEn, e.pcSrcAtEn);
      check({p, "_memToReg"}, a.memToReg, e.memToReg);
      check({p, "_ALUOp"}, a.aluOp, e.aluOp);
      check({p, "_ALUSrc"}, a.aluSrc, e.aluSrc);
      check({p, "_registerB"}, a.regB, e.regB);
      check({p, "_branch"}, a.branch, e.branch);
      check({p, "_illegal"}, a.ill, e.ill);
      check({p, "_memTimeout"}, a.tmo, e.tmo);
      check({p, "_bothStrobesLow"}, a.bothLow, e.bothLow);
      check({p, "_busyVsReady"}, a.busyBad, e.busyBad);
      check({p, "_fetchClean"}, a.clean, e.clean);
   endtask

   // Monitor: an instruction starts when instrReady falls and retires when it rises again.
   initial begin : monitor
      recT acc;
      bit  inFlight;
      bit  prevReady;
      recT e;
      inFlight  = 1'b0;
      prevReady = 1'b0;
      acc = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      forever begin
         @(negedge clock);
         if (!resetN) begin
            inFlight  = 1'b0;
            prevReady = 1'b0;
         end else begin
            if (!inFlight && prevReady && !instrReady) begin
               inFlight = 1'b1;
               acc = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
               acc.aluOp = int'(ALUOp); acc.aluSrc = int'(ALUSrc); acc.regB = int'(registerB);
               acc.branch = int'(branch); acc.memToReg = int'(memToReg);
            end
            if (inFlight) begin
               acc.rdLow   += int'(!memRead);
               acc.wrLow   += int'(!memWrite);
               acc.regWr   += int'(regWrite);
               acc.pcEn    += int'(pcEnable);
               if (pcEnable) acc.pcSrcAtEn = int'(pcSrc);
               acc.ill     += int'(illegal);
               acc.tmo     += int'(memTimeout);
               acc.bothLow += int'(!memRead && !memWrite);
               acc.busyBad += int'(busy == instrReady);
               if (!instrReady) begin
                  acc.busyCyc++;
               end else begin
                  acc.clean = int'(ALUOp == '0 && !ALUSrc && !registerB && !branch && !memToReg &&
                                   !pcSrc && memRead && memWrite && !regWrite && !pcEnable && !illegal);
                  if (expQ.size() == 0) begin
                     check("spurious_instruction", expQ.size(), 1);
                  end else begin
                     e = expQ.pop_front();
                     compareRec(acc, e);
                  end
                  inFlight = 1'b0;
               end
            end
            prevReady = instrReady;
         end
      end
   end

   // Memory responder: raises memReady once a strobe has been low for memDelay cycles.
   initial begin : memModel
      int lowCnt;
      lowCnt   = 0;
      memReady = 1'b0;
      forever begin
         @(negedge clock);
         if (resetN && memDelay < 0) begin
            memReady = 1'b1;
            lowCnt   = 0;
         end else if (resetN && (!memRead || !memWrite)) begin
            memReady = (lowCnt >= memDelay);
            lowCnt++;
         end else begin
            memReady = 1'b0;
            lowCnt   = 0;
         end
      end
   end

   task automatic waitReady(input string name);
      int n;
      n = 0;
      @(negedge clock);
      while (!instrReady && n < 100) begin
         @(negedge clock);
         n++;
      end
      check(name, int'(instrReady), 1);
   endtask

   // Present one word for one accept, optionally waving a bogus word while busy.
   task automatic issue(input logic [IW-1:0] instr, input logic zero, input int delay,
                        input recT e, input bit junk);
      int n;
      waitReady($sformatf("instr%0d_readyWait", e.id));
      instruction = instr;
      instrValid  = 1'b1;
      aluZero     = zero;
      memDelay    = delay;
      expQ.push_back(e);
      @(negedge clock);
      if (junk) begin
         instruction = 32'hE000_0000;
         @(negedge clock);
      end
      instrValid = 1'b0;
      n = 0;
      while (expQ.size() != 0 && n < 200) begin
         @(negedge clock);
         n++;
      end
      check($sformatf("instr%0d_retired", e.id), expQ.size(), 0);
   endtask

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      int n;
      resetN      = 1'b0;
      instruction = '0;
      instrValid  = 1'b0;
      aluZero     = 1'b0;
      repeat (3) @(negedge clock);
      check("rst_memRead", int'(memRead), 1);
      check("rst_memWrite", int'(memWrite), 1);
      check("rst_instrReady", int'(instrReady), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_ALUOp", int'(ALUOp), 0);
      check("rst_pcEnable", int'(pcEnable), 0);
      resetN = 1'b1;
      @(negedge clock);
      check("rel_instrReady", int'(instrReady), 1);

      //      id busy rd  wr rw pe ps m2r op src rb br ill tmo
      issue(32'h2000_0000, 1'b0, -1,   mk(1,  3, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1);
      issue(32'h2B00_0000, 1'b0, -1,   mk(2,  3, 0, 0, 1, 1, 0, 0, 11, 0, 0, 0, 0, 0), 1'b0);
      issue(32'h8000_0000, 1'b0, 3,    mk(3,  7, 4, 0, 1, 1, 0, 1, 0, 1, 0, 0, 0, 0), 1'b0);
      issue(32'h8000_0000, 1'b0, -1,   mk(4,  4, 1, 0, 1, 1, 0, 1, 0, 1, 0, 0, 0, 0), 1'b0);
      issue(32'h8100_0000, 1'b0, -1,   mk(5,  4, 0, 1, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0), 1'b0);
      issue(32'hA400_0000, 1'b1, -1,   mk(6,  3, 0, 0, 0, 1, 1, 0, 2, 0, 1, 1, 0, 0), 1'b0);
      issue(32'hA400_0000, 1'b0, -1,   mk(7,  3, 0, 0, 0, 1, 0, 0, 2, 0, 1, 1, 0, 0), 1'b0);
      issue(32'hA800_0000, 1'b0, -1,   mk(8,  3, 0, 0, 0, 1, 1, 0, 7, 0, 1, 1, 0, 0), 1'b0);
      issue(32'hA800_0000, 1'b1, -1,   mk(9,  3, 0, 0, 0, 1, 0, 0, 7, 0, 1, 1, 0, 0), 1'b0);
      issue(32'hA000_0000, 1'b0, -1,   mk(10, 3, 0, 0, 0, 1, 1, 0, 10, 0, 1, 1, 0, 0), 1'b0);
      issue(32'h4200_0000, 1'b0, -1,   mk(11, 3, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0), 1'b0);
      issue(32'h0000_0000, 1'b0, -1,   mk(12, 2, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0), 1'b0);
      issue(32'hE000_0000, 1'b0, -1,   mk(13, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 1'b0);
      issue(32'h4000_0000, 1'b0, -1,   mk(14, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 1'b0);
      issue(32'hAC00_0000, 1'b0, -1,   mk(15, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 1'b0);
      issue(32'h8100_0000, 1'b0, 1000, mk(16, 17, 0, 15, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1), 1'b0);
      issue(32'h8000_0000, 1'b0, 2,    mk(17, 6, 3, 0, 1, 1, 0, 1, 0, 1, 0, 0, 0, 0), 1'b0);

      // Asynchronous reset in the middle of a stalled load.
      waitReady("midrst_readyWait");
      instruction = 32'h8000_0000;
      instrValid  = 1'b1;
      memDelay    = 1000;
      @(negedge clock);
      instrValid = 1'b0;
      n = 0;
      while (memRead && n < 20) begin
         @(negedge clock);
         n++;
      end
      check("midrst_memEntered", int'(memRead), 0);
      repeat (2) @(negedge clock);
      #2 resetN = 1'b0;
      #1;
      check("midrst_memRead", int'(memRead), 1);
      check("midrst_memWrite", int'(memWrite), 1);
      check("midrst_instrReady", int'(instrReady), 0);
      check("midrst_busy", int'(busy), 0);
      check("midrst_ALUSrc", int'(ALUSrc), 0);
      check("midrst_memToReg", int'(memToReg), 0);
      check("midrst_regWrite", int'(regWrite), 0);
      @(negedge clock);
      @(negedge clock);
      memDelay = -1;
      resetN   = 1'b1;
      #1;
      check("midrst_readyBeforeEdge", int'(instrReady), 0);
      @(negedge clock);
      check("midrst_readyAfterEdge", int'(instrReady), 1);
      check("midrst_busyAfterEdge", int'(busy), 0);

      issue(32'h2000_0000, 1'b0, -1,   mk(18, 3, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);

      check("final_queueEmpty", expQ.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
      $finish;
   end
endmodule
